// File: rtl/team_06_audio_pkg.sv
// team_06_audio_pkg: shared mode/effect types, silence code and deviation helpers
// for the audio datapath.
package team_06_audio_pkg;
    typedef enum logic [1:0] {IDLE, LISTEN, TALK, RSVD} state_t;
    typedef enum logic [2:0] {EFF_NONE, EFF_CRUSH, EFF_INV, EFF_DECIM, EFF_HALFW} effect_t;
    localparam logic [7:0] MID = 8'd128;
    function automatic logic signed [7:0] sat8(input logic signed [9:0] x);
        return (x > 10'sd127) ? 8'h7f : (x < -10'sd128) ? 8'h80 : x[7:0];
    endfunction
    // offset binary <-> two's complement deviation is just an MSB flip
    function automatic logic signed [7:0] dev(input logic [7:0] s);
        return {~s[7], s[6:0]};
    endfunction
    function automatic logic [7:0] to_ob(input logic signed [7:0] d);
        return {~d[7], d[6:0]};
    endfunction
endpackage

// File: rtl/team_06_audio_proc_noise_gate.sv
// team_06_noise_gate: threshold compare with hold-off counter; the sample that
// completes the hold still passes, gating applies from the next one.
module team_06_noise_gate #(
    parameter int NG_THRESH = 8,
    parameter int NG_HOLD   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic              enable,
    input  logic signed [7:0] d,
    output logic              pass,
    output logic              gate_open
);
    localparam logic signed [8:0] TH   = 9'(NG_THRESH);
    localparam logic [7:0]        HOLD = 8'(NG_HOLD);
    logic signed [8:0] dx, mag;
    logic [7:0] cnt, cnt_nxt;
    logic loud;
    assign dx      = {d[7], d};
    assign mag     = d[7] ? -dx : dx;
    assign loud    = mag >= TH;
    assign cnt_nxt = (cnt == HOLD) ? cnt : cnt + 8'd1;
    assign pass    = !enable || loud || gate_open;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            gate_open <= 1'b1;
        end else if (!enable || (valid && loud)) begin
            cnt       <= '0;
            gate_open <= 1'b1;
        end else if (valid) begin
            cnt       <= cnt_nxt;
            gate_open <= cnt_nxt != HOLD;
        end
    end
endmodule

// File: rtl/team_06_audio_proc.sv
// team_06_audio_proc: 3-stage audio path (select -> gate+effect -> volume+mute)
// producing one offset-binary sample per input strobe.
module team_06_audio_proc
    import team_06_audio_pkg::*;
#(
    parameter int NG_THRESH = 8,
    parameter int NG_HOLD   = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       samp_valid,
    input  logic [7:0] mic_aud,
    input  logic [7:0] spk_aud,
    input  logic [1:0] state,
    input  logic       eff_en,
    input  logic [2:0] current_effect,
    input  logic       vol_en,
    input  logic [1:0] vol,
    input  logic       mute_tog,
    input  logic       noise_gate_tog,
    output logic [7:0] aud_out,
    output logic       out_valid,
    output logic       gate_open
);
    state_t st;
    effect_t eff;
    logic v1, v2, pass, phase, decim;
    logic [7:0] hold;
    logic signed [7:0] sel, d1, g, fx, d2, vx;
    assign st  = state_t'(state);
    assign sel = (st == LISTEN) ? dev(spk_aud) : (st == TALK) ? dev(mic_aud) : 8'sd0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else begin
            v1 <= samp_valid;
            d1 <= sel;
        end
    end
    team_06_noise_gate #(.NG_THRESH(NG_THRESH), .NG_HOLD(NG_HOLD)) u_gate (
        .clk       (clk),
        .rst       (rst),
        .valid     (v1),
        .enable    (noise_gate_tog),
        .d         (d1),
        .pass      (pass),
        .gate_open (gate_open)
    );
    assign eff   = effect_t'(current_effect);
    assign decim = eff_en && eff == EFF_DECIM;
    assign g     = pass ? d1 : 8'sd0;
    assign fx    = !eff_en ? g :
                   (eff == EFF_CRUSH) ? (g & 8'shf0) :
                   (eff == EFF_INV)   ? sat8(-10'(g)) :
                   (eff == EFF_DECIM) ? (phase ? dev(hold) : g) :
                   (eff == EFF_HALFW) ? (g[7] ? 8'sd0 : g) : g;
    // leaving decimate mode (disable or effect change) restarts the phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2    <= 1'b0;
            d2    <= '0;
            phase <= 1'b0;
            hold  <= MID;
        end else begin
            v2    <= v1;
            d2    <= fx;
            phase <= decim ? phase ^ v1 : 1'b0;
            hold  <= (decim && v1 && !phase) ? to_ob(g) : hold;
        end
    end
    assign vx = !vol_en ? d2 :
                (vol == 2'd0) ? d2 >>> 2 :
                (vol == 2'd1) ? d2 >>> 1 :
                (vol == 2'd2) ? d2 : sat8(10'(d2) <<< 1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            aud_out   <= MID;
        end else begin
            out_valid <= v2;
            aud_out   <= v2 ? (mute_tog ? MID : to_ob(vx)) : aud_out;
        end
    end
endmodule

// File: tb/tb_team_06_audio_proc.sv
// tb_team_06_audio_proc: directed and randomized checks of the audio path against
// a sample-queue reference model.
module tb_team_06_audio_proc;
    localparam int NG_T = 8;
    localparam int HOLD = 4;
    logic clk = 0, rst = 0, samp_valid = 0, eff_en = 0, vol_en = 0, mute_tog = 0, noise_gate_tog = 0;
    logic [7:0] mic_aud = 0, spk_aud = 0;
    logic [1:0] state = 0, vol = 0;
    logic [2:0] current_effect = 0;
    logic [7:0] aud_out;
    logic out_valid, gate_open;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    team_06_audio_proc #(.NG_THRESH(NG_T), .NG_HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .samp_valid(samp_valid), .mic_aud(mic_aud), .spk_aud(spk_aud),
        .state(state), .eff_en(eff_en), .current_effect(current_effect), .vol_en(vol_en),
        .vol(vol), .mute_tog(mute_tog), .noise_gate_tog(noise_gate_tog),
        .aud_out(aud_out), .out_valid(out_valid), .gate_open(gate_open)
    );

    typedef struct { int stage; int d; } item_t;
    item_t pipe[$];
    int m_open, m_cnt, m_phase, m_hold, m_aud;
    bit m_ov;

    function automatic int clamp(int x);
        return x > 127 ? 127 : (x < -128 ? -128 : x);
    endfunction

    task automatic model_reset();
        pipe.delete();
        m_open = 1; m_cnt = 0; m_phase = 0; m_hold = 0; m_aud = 128; m_ov = 0;
    endtask

    function automatic int gate_effect(int d);
        int x = d;
        if (noise_gate_tog) begin
            if (x >= NG_T || x <= -NG_T) begin
                m_open = 1; m_cnt = 0;
            end else begin
                if (m_open == 0) x = 0;
                m_cnt = (m_cnt < HOLD) ? m_cnt + 1 : HOLD;
                if (m_cnt == HOLD) m_open = 0;
            end
        end
        if (eff_en)
            case (current_effect)
                3'd1: x = x & ~15;
                3'd2: x = clamp(-x);
                3'd3: begin
                    if (m_phase == 0) m_hold = x; else x = m_hold;
                    m_phase = 1 - m_phase;
                end
                3'd4: if (x < 0) x = 0;
                default: ;
            endcase
        return x;
    endfunction

    function automatic int volume(int d);
        if (!vol_en) return d;
        case (vol)
            2'd0: return d >>> 2;
            2'd1: return d >>> 1;
            2'd2: return d;
            default: return clamp(2 * d);
        endcase
    endfunction

    task automatic model_step();
        item_t nq[$];
        m_ov = 0;
        foreach (pipe[i]) begin
            item_t it = pipe[i];
            if (it.stage == 2) begin
                m_aud = mute_tog ? 128 : volume(it.d) + 128;
                m_ov = 1;
            end else begin
                it.d = gate_effect(it.d);
                it.stage = 2;
                nq.push_back(it);
            end
        end
        if (!noise_gate_tog) begin m_open = 1; m_cnt = 0; end
        if (!(eff_en && current_effect == 3'd3)) m_phase = 0;
        if (samp_valid)
            nq.push_back('{1, state == 2'd1 ? int'(spk_aud) - 128 : state == 2'd2 ? int'(mic_aud) - 128 : 0});
        pipe = nq;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== m_ov) begin errors++; $display("FAIL out_valid t=%0t got %b exp %b", $time, out_valid, m_ov); end
        checks++;
        if (aud_out !== m_aud[7:0]) begin errors++; $display("FAIL aud_out t=%0t got %0d exp %0d", $time, aud_out, m_aud); end
        checks++;
        if (gate_open !== m_open[0]) begin errors++; $display("FAIL gate_open t=%0t got %b exp %0d", $time, gate_open, m_open); end
    endtask

    task automatic run_seq(input int vals[$], output int got[$]);
        got = {};
        foreach (vals[i]) begin
            samp_valid = 1; spk_aud = 8'(vals[i]);
            tick();
            if (out_valid) got.push_back(int'(aud_out));
        end
        samp_valid = 0;
        repeat (4) begin
            tick();
            if (out_valid) got.push_back(int'(aud_out));
        end
    endtask

    task automatic test_reset();
        rst = 0;
        @(negedge clk);
        model_reset();
        checks++;
        if (aud_out !== 8'd128 || out_valid !== 1'b0 || gate_open !== 1'b1) begin
            errors++; $display("FAIL reset_state got aud=%0d ov=%b go=%b exp 128/0/1", aud_out, out_valid, gate_open);
        end
        rst = 1;
        repeat (2) tick();
    endtask

    task automatic test_listen();
        state = 2'd1; spk_aud = 8'd200; samp_valid = 1;
        tick();
        samp_valid = 0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL listen_early got %b exp 0", out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || aud_out !== 8'd200) begin errors++; $display("FAIL listen_out got ov=%b aud=%0d exp 1/200", out_valid, aud_out); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL listen_pulse got %b exp 0", out_valid); end
    endtask

    task automatic test_volume();
        state = 2'd2; vol_en = 1; vol = 2'd0; mic_aud = 8'd100; samp_valid = 1;
        tick();
        samp_valid = 0;
        repeat (3) tick();
        checks++;
        if (aud_out !== 8'd121) begin errors++; $display("FAIL vol_quarter got %0d exp 121", aud_out); end
        vol = 2'd3; mic_aud = 8'd250; samp_valid = 1;
        tick();
        samp_valid = 0;
        repeat (3) tick();
        checks++;
        if (aud_out !== 8'd255) begin errors++; $display("FAIL vol_double_sat got %0d exp 255", aud_out); end
        vol_en = 0; vol = 2'd0;
    endtask

    task automatic test_gate();
        int got[$];
        int exp_q[$];
        state = 2'd1; noise_gate_tog = 1;
        run_seq('{130, 130, 130, 130, 130, 130, 150}, got);
        exp_q = '{130, 130, 130, 130, 128, 128, 150};
        checks++;
        if (got.size() != exp_q.size()) begin errors++; $display("FAIL gate_count got %0d exp %0d", got.size(), exp_q.size()); end
        foreach (got[i]) if (i < exp_q.size()) begin
            checks++;
            if (got[i] != exp_q[i]) begin errors++; $display("FAIL gate_out[%0d] got %0d exp %0d", i, got[i], exp_q[i]); end
        end
        checks++;
        if (gate_open !== 1'b1) begin errors++; $display("FAIL gate_reopen got %b exp 1", gate_open); end
        noise_gate_tog = 0;
    endtask

    task automatic test_effects();
        int got[$];
        int exp_q[$];
        state = 2'd1; eff_en = 1; current_effect = 3'd3;
        run_seq('{10, 20, 30, 40}, got);
        exp_q = '{10, 10, 30, 30};
        checks++;
        if (got.size() != exp_q.size()) begin errors++; $display("FAIL decim_count got %0d exp %0d", got.size(), exp_q.size()); end
        foreach (got[i]) if (i < exp_q.size()) begin
            checks++;
            if (got[i] != exp_q[i]) begin errors++; $display("FAIL decim_out[%0d] got %0d exp %0d", i, got[i], exp_q[i]); end
        end
        current_effect = 3'd2;
        run_seq('{0}, got);
        checks++;
        if (got.size() != 1 || got[0] != 255) begin errors++; $display("FAIL invert_sat got n=%0d v=%0d exp 255", got.size(), got.size() ? got[0] : -1); end
        eff_en = 0; current_effect = 3'd0;
    endtask

    task automatic test_mute();
        int got[$];
        state = 2'd1; mute_tog = 1;
        run_seq('{250, 250, 250}, got);
        checks++;
        if (got.size() != 3) begin errors++; $display("FAIL mute_pulses got %0d exp 3", got.size()); end
        foreach (got[i]) begin
            checks++;
            if (got[i] != 128) begin errors++; $display("FAIL mute_out[%0d] got %0d exp 128", i, got[i]); end
        end
        mute_tog = 0;
        run_seq('{250}, got);
        checks++;
        if (got.size() != 1 || got[0] != 250) begin errors++; $display("FAIL unmute got n=%0d v=%0d exp 250", got.size(), got.size() ? got[0] : -1); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            samp_valid = ($urandom_range(3) != 0);
            mic_aud = 8'($urandom);
            spk_aud = ($urandom_range(1) != 0) ? 8'($urandom_range(140, 116)) : 8'($urandom);
            if ($urandom_range(3) == 0) state = 2'($urandom);
            if ($urandom_range(5) == 0) eff_en = 1'($urandom);
            if ($urandom_range(5) == 0) current_effect = 3'($urandom);
            if ($urandom_range(3) == 0) vol_en = 1'($urandom);
            if ($urandom_range(3) == 0) vol = 2'($urandom);
            mute_tog = ($urandom_range(9) == 0);
            if ($urandom_range(7) == 0) noise_gate_tog = 1'($urandom);
            tick();
        end
        samp_valid = 0; eff_en = 0; current_effect = 0; vol_en = 0; vol = 0; mute_tog = 0; noise_gate_tog = 0;
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        int got[$];
        state = 2'd1; noise_gate_tog = 1;
        run_seq('{131, 131, 131, 131}, got);
        checks++;
        if (gate_open !== 1'b0 || aud_out !== 8'd131) begin errors++; $display("FAIL pre_reset got go=%b aud=%0d exp 0/131", gate_open, aud_out); end
        spk_aud = 8'd200; samp_valid = 1;
        tick();
        rst = 0;
        model_reset();
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        samp_valid = 0; noise_gate_tog = 0; rst = 1;
        repeat (5) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || aud_out !== 8'd128 || gate_open !== 1'b1) begin
                errors++; $display("FAIL reset_mid got ov=%b aud=%0d go=%b exp 0/128/1", out_valid, aud_out, gate_open);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_listen();
        test_volume();
        test_gate();
        test_effects();
        test_mute();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/team_06_audio_proc.md
Name: team_06_audio_proc

Overview:
- Audio datapath stage directly downstream of the key/FSM control block.
- Consumes its mode and enable outputs (state, eff_en, vol_en, current_effect, mute_tog, noise_gate_tog) together with per-sample mic/speaker audio.
- Produces one processed 8-bit offset-binary sample per input strobe: source select, noise gate, effect, volume, mute.
- Fixed 3-cycle valid pipeline; feeds the PWM/DAC output stage.

Parameters:
- NG_THRESH, 8, gate opens when |sample-128| >= NG_THRESH.
- NG_HOLD, 64, consecutive sub-threshold samples before the gate closes (1..255).
- MID, 8'd128, silence code (offset-binary midpoint).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- samp_valid  input  1  one-cycle strobe; mic_aud/spk_aud are valid this cycle
- mic_aud  input  8  microphone sample, offset binary
- spk_aud  input  8  received/speaker sample, offset binary
- state  input  2  0 IDLE, 1 LISTEN, 2 TALK, 3 reserved
- eff_en  input  1  effect stage enable
- current_effect  input  3  effect select
- vol_en  input  1  volume stage enable
- vol  input  2  volume level
- mute_tog  input  1  level: 1 = muted
- noise_gate_tog  input  1  level: 1 = gate enabled
- aud_out  output  8  processed sample
- out_valid  output  1  one-cycle strobe, aud_out valid
- gate_open  output  1  current noise-gate status

Behaviour:
- Reset (rst=0, async): aud_out=MID, out_valid=0, gate_open=1, hold counter=0, decimator phase=0, decimator hold register=MID, all pipeline valids=0.
- Pipeline: S1 select, S2 gate+effect, S3 volume+mute. A samp_valid in cycle N gives out_valid in cycle N+3. Back-to-back strobes are accepted every cycle. There is no backpressure.
- Control inputs are sampled in the stage that uses them, in the same cycle the sample passes through.
- S1 select: LISTEN uses spk_aud, TALK uses mic_aud, IDLE and reserved give MID.
- Deviation d = sample-128, signed 9-bit. All arithmetic works on d and saturates to [-128,127] before re-adding 128.
- S2 gate (noise_gate_tog=1), evaluated only on valid samples:
  - |d| >= NG_THRESH: gate_open=1, counter=0.
  - Otherwise the counter increments, saturating at NG_HOLD. When it reaches NG_HOLD, gate_open=0.
  - Gate closed: output MID. The sample that reaches the threshold passes unchanged; gating starts with the next sample.
  - noise_gate_tog=0: gate_open=1, counter cleared, sample passes.
- S2 effect (eff_en=1); with eff_en=0 the sample passes:
  - 0 none.
  - 1 bitcrush: d with low 4 bits cleared.
  - 2 invert: -d, saturate (-(-128) becomes 127).
  - 3 decimate: phase toggles per valid sample. Phase 0 captures the sample into the hold register; phase 1 outputs the hold register. Phase is cleared when eff_en falls or the effect changes.
  - 4 half-wave: d<0 becomes 0.
  - 5-7 pass.
- S3 volume: vol_en=0 gives d unchanged. Otherwise:
  - vol=0: d>>>2
  - vol=1: d>>>1
  - vol=2: d
  - vol=3: d<<1, saturated
- S3 mute: mute_tog=1 forces MID, overriding everything. out_valid still pulses.
- A state change mid-pipeline only affects samples entering S1 afterwards. In-flight samples complete.
- Reset asserted mid-pipeline drops all in-flight samples. No out_valid follows.

Decomposition:
- team_06_audio_pkg holds:
  - state_t enum (IDLE, LISTEN, TALK, RSVD)
  - effect_t enum (EFF_NONE, EFF_CRUSH, EFF_INV, EFF_DECIM, EFF_HALFW)
  - MID constant
  - a sat8 function (signed 10-bit to signed 8-bit)
- Sub-module team_06_noise_gate holds the threshold compare, hold counter and gate_open. It is instantiated in S2.

Test Plan:
- Reset, then state=LISTEN, spk_aud=200, all enables 0, strobe -> aud_out=200 exactly 3 cycles later; out_valid high one cycle.
- TALK, mic_aud=100, vol_en=1, vol=0 -> d=-28, output 121. vol=3, mic_aud=250 -> saturates to 255.
- noise_gate_tog=1, NG_HOLD=4, samples 130 x6 -> first 4 outputs 130, then 128; next sample 150 -> 150, gate_open=1.
- eff_en=1, effect=3, samples 10,20,30,40 -> 10,10,30,30. effect=2 with sample 0 -> 255.
- mute_tog=1 with every sample 250 -> 128, out_valid still pulsing. Deassert -> the next sample passes.
- Strobes on 3 consecutive cycles, rst pulsed low in the 2nd cycle -> no out_valid afterwards, aud_out=128, gate_open=1.
